// File: rtl/serial_rf_pkg.sv
// Shared state encoding and parameter-derived sizing for the bit-serial register file.
package serial_rf_pkg;

   typedef enum logic {
      RF_IDLE = 1'b0,
      RF_RUN  = 1'b1
   } rf_state_t;

   // Number of beats needed to stream one full register.
   function automatic int rf_beats(input int xlen, input int slice);
      return xlen / slice;
   endfunction

   function automatic int rf_aw(input int nreg);
      return (nreg > 1) ? $clog2(nreg) : 1;
   endfunction

   // Width of a counter/index over n positions; never narrower than one bit.
   function automatic int rf_cw(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/serial_beat_ctr.sv
// Beat counter for serial transactions; also reused by the serial ALU sequencer.
module serial_beat_ctr
   import serial_rf_pkg::*;
#(
   parameter int BEATS = 16
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   input  logic                       en,
   output logic [rf_cw(BEATS)-1:0]    cnt,
   output logic                       last
);

   localparam int CW = rf_cw(BEATS);
   localparam logic [CW-1:0] CNT_MAX = CW'(BEATS - 1);

   assign last = en && (cnt == CNT_MAX);

   // Wrap explicitly so non-power-of-two beat counts restart cleanly.
   always_ff @(posedge clk) begin
      if (rst || clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= last ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/serial_reg_file.sv
// Bit-serial register file: streams two source registers slice-by-slice and
// writes back one result slice per beat, with a parallel debug read port.
module serial_reg_file
   import serial_rf_pkg::*;
#(
   parameter int XLEN     = 16,
   parameter int NREG     = 8,
   parameter int SLICE    = 1,
   parameter int ZERO_REG = 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [rf_aw(NREG)-1:0]   rs1,
   input  logic [rf_aw(NREG)-1:0]   rs2,
   input  logic [rf_aw(NREG)-1:0]   rd,
   input  logic                     rd_we,
   output logic                     ready,
   output logic                     busy,
   output logic                     last,
   output logic [SLICE-1:0]         rs1_slice,
   output logic [SLICE-1:0]         rs2_slice,
   input  logic [SLICE-1:0]         rd_slice,
   input  logic [rf_aw(NREG)-1:0]   dbg_addr,
   output logic [XLEN-1:0]          dbg_data
);

   localparam int BEATS = rf_beats(XLEN, SLICE);
   localparam int AW    = rf_aw(NREG);
   localparam int CW    = rf_cw(BEATS);
   localparam int BW    = rf_cw(XLEN);

   if (SLICE < 1 || (XLEN % SLICE) != 0) begin : g_bad_slice
      $error("serial_reg_file: SLICE must divide XLEN");
   end
   if (NREG < 2) begin : g_bad_nreg
      $error("serial_reg_file: NREG must be at least 2");
   end

   rf_state_t       state;
   logic [AW-1:0]   rs1_q, rs2_q, rd_q;
   logic            rd_we_q;
   logic [XLEN-1:0] regs [NREG];
   logic [CW-1:0]   cnt;
   logic [BW-1:0]   base;
   logic [XLEN-1:0] rs1_word, rs2_word;
   logic            accept, wr_en;

   function automatic logic is_zero(input logic [AW-1:0] a);
      return (ZERO_REG != 0) && (a == '0);
   endfunction

   assign busy   = (state == RF_RUN);
   assign ready  = (state == RF_IDLE) || last;
   assign accept = start && ready;
   assign base   = BW'(32'(cnt) * 32'(SLICE));

   assign rs1_word  = is_zero(rs1_q) ? '0 : regs[rs1_q];
   assign rs2_word  = is_zero(rs2_q) ? '0 : regs[rs2_q];
   assign rs1_slice = busy ? rs1_word[base +: SLICE] : '0;
   assign rs2_slice = busy ? rs2_word[base +: SLICE] : '0;
   assign dbg_data  = is_zero(dbg_addr) ? '0 : regs[dbg_addr];

   // Reads are combinational off the current beat, the write lands at the edge,
   // so rd == rs aliasing always streams the pre-transaction value.
   assign wr_en = busy && rd_we_q && !is_zero(rd_q);

   serial_beat_ctr #(.BEATS(BEATS)) u_ctr (
      .clk  (clk),
      .rst  (rst),
      .clr  (accept),
      .en   (busy),
      .cnt  (cnt),
      .last (last)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= RF_IDLE;
         rs1_q   <= '0;
         rs2_q   <= '0;
         rd_q    <= '0;
         rd_we_q <= 1'b0;
         for (int i = 0; i < NREG; i++) regs[i] <= '0;
      end else begin
         if (accept) begin
            state   <= RF_RUN;
            rs1_q   <= rs1;
            rs2_q   <= rs2;
            rd_q    <= rd;
            rd_we_q <= rd_we;
         end else if (last) begin
            state <= RF_IDLE;
         end
         if (wr_en) regs[rd_q][base +: SLICE] <= rd_slice;
      end
   end

endmodule

// File: tb/tb_serial_reg_file.sv
// Bench for serial_reg_file: a SLICE=1/ZERO_REG=1 instance and a SLICE=4/ZERO_REG=0
// instance, driven by a directed vector table and random transactions against a word-level model.
module tb_serial_reg_file;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic        i_start [2];
   logic [2:0]  i_rs1 [2], i_rs2 [2], i_rd [2], i_dbg [2];
   logic        i_we [2];
   logic [3:0]  i_rds [2];
   logic        o_ready [2], o_busy [2], o_last [2];
   logic [15:0] o_dbg [2];
   logic [3:0]  o_s1 [2], o_s2 [2];
   logic        d0_s1, d0_s2;
   logic [3:0]  d1_s1, d1_s2;

   assign o_s1[0] = {3'b000, d0_s1};
   assign o_s2[0] = {3'b000, d0_s2};
   assign o_s1[1] = d1_s1;
   assign o_s2[1] = d1_s2;

   serial_reg_file #(.XLEN(16), .NREG(8), .SLICE(1), .ZERO_REG(1)) dut0 (
      .clk(clk), .rst(rst), .start(i_start[0]),
      .rs1(i_rs1[0]), .rs2(i_rs2[0]), .rd(i_rd[0]), .rd_we(i_we[0]),
      .ready(o_ready[0]), .busy(o_busy[0]), .last(o_last[0]),
      .rs1_slice(d0_s1), .rs2_slice(d0_s2), .rd_slice(i_rds[0][0:0]),
      .dbg_addr(i_dbg[0]), .dbg_data(o_dbg[0])
   );

   serial_reg_file #(.XLEN(16), .NREG(8), .SLICE(4), .ZERO_REG(0)) dut1 (
      .clk(clk), .rst(rst), .start(i_start[1]),
      .rs1(i_rs1[1]), .rs2(i_rs2[1]), .rd(i_rd[1]), .rd_we(i_we[1]),
      .ready(o_ready[1]), .busy(o_busy[1]), .last(o_last[1]),
      .rs1_slice(d1_s1), .rs2_slice(d1_s2), .rd_slice(i_rds[1]),
      .dbg_addr(i_dbg[1]), .dbg_data(o_dbg[1])
   );

   int n_chk = 0;
   int n_fail = 0;
   logic [15:0] mdl [2][8];

   typedef struct {
      int          d, a1, a2, ad;
      bit          we;
      logic [15:0] wd;
      int          junk;
      bit          chain;
      logic [15:0] e1, e2, erd;
   } vec_t;
   vec_t tbl [9];

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Word-level model: dut0 hardwires r0 to zero, dut1 does not.
   function automatic logic [15:0] mread(input int d, input int a);
      return (d == 0 && a == 0) ? 16'h0000 : mdl[d][a];
   endfunction

   function automatic bit mwr_ok(input int d, input int a, input bit we);
      return we && !(d == 0 && a == 0);
   endfunction

   task automatic clear_model();
      for (int d = 0; d < 2; d++)
         for (int a = 0; a < 8; a++) mdl[d][a] = 16'h0000;
   endtask

   // Called in the cycle the start is presented (ready must be high).
   task automatic txn(input int d, input int a1, input int a2, input int ad, input bit we,
                      input logic [15:0] wd, input int junk, input bit chain,
                      input logic [15:0] e1, input logic [15:0] e2, input logic [15:0] erd,
                      input string tag);
      int s, b;
      logic [15:0] g1, g2;
      s = (d == 0) ? 1 : 4;
      b = 16 / s;
      g1 = '0;
      g2 = '0;
      i_start[d] = 1'b1;
      i_rs1[d] = 3'(a1);
      i_rs2[d] = 3'(a2);
      i_rd[d]  = 3'(ad);
      i_we[d]  = we;
      if (mwr_ok(d, ad, we)) mdl[d][ad] = wd;
      step();
      for (int k = 0; k < b; k++) begin
         i_start[d] = (k == junk);
         if (k == junk) begin
            i_rs1[d] = 3'($urandom);
            i_rs2[d] = 3'($urandom);
            i_rd[d]  = 3'($urandom);
            i_we[d]  = 1'b1;
         end
         i_rds[d] = 4'(wd >> (k * s));
         @(negedge clk);
         chk($sformatf("%s ctl beat%0d", tag, k), {o_busy[d], o_last[d], o_ready[d]},
             {1'b1, k == b - 1, k == b - 1});
         g1 |= 16'(o_s1[d]) << (k * s);
         g2 |= 16'(o_s2[d]) << (k * s);
         if (k < b - 1 || !chain) step();
      end
      chk($sformatf("%s rs1 stream", tag), g1, e1);
      chk($sformatf("%s rs2 stream", tag), g2, e2);
      if (!chain) begin
         chk($sformatf("%s idle ctl", tag), {o_busy[d], o_last[d], o_ready[d]}, 3'b001);
         i_dbg[d] = 3'(ad);
         #1;
         chk($sformatf("%s dbg rd", tag), o_dbg[d], erd);
      end
   endtask

   initial begin
      for (int d = 0; d < 2; d++) begin
         i_start[d] = 1'b0; i_rs1[d] = '0; i_rs2[d] = '0; i_rd[d] = '0;
         i_we[d] = 1'b0; i_rds[d] = '0; i_dbg[d] = '0;
      end
      clear_model();

      tbl[0] = '{0, 0, 0, 3, 1'b1, 16'hA5C3, -1, 1'b0, 16'h0000, 16'h0000, 16'hA5C3};
      tbl[1] = '{0, 3, 0, 5, 1'b1, 16'h0F0F, -1, 1'b0, 16'hA5C3, 16'h0000, 16'h0F0F};
      tbl[2] = '{0, 3, 5, 3, 1'b1, 16'hFFFF, -1, 1'b0, 16'hA5C3, 16'h0F0F, 16'hFFFF};
      tbl[3] = '{0, 0, 3, 0, 1'b1, 16'h1234, -1, 1'b0, 16'h0000, 16'hFFFF, 16'h0000};
      tbl[4] = '{0, 0, 0, 1, 1'b0, 16'hBEEF, -1, 1'b0, 16'h0000, 16'h0000, 16'h0000};
      tbl[5] = '{1, 0, 0, 0, 1'b1, 16'h1234, -1, 1'b0, 16'h0000, 16'h0000, 16'h1234};
      tbl[6] = '{1, 0, 0, 2, 1'b1, 16'hBEEF,  2, 1'b0, 16'h1234, 16'h1234, 16'hBEEF};
      tbl[7] = '{1, 2, 0, 7, 1'b1, 16'hCAFE, -1, 1'b1, 16'hBEEF, 16'h1234, 16'hCAFE};
      tbl[8] = '{1, 7, 2, 2, 1'b0, 16'h0000, -1, 1'b0, 16'hCAFE, 16'hBEEF, 16'hBEEF};

      rst = 1'b1;
      repeat (2) step();
      rst = 1'b0;

      for (int d = 0; d < 2; d++) begin
         chk($sformatf("reset ctl d%0d", d), {o_ready[d], o_busy[d], o_last[d]}, 3'b100);
         chk($sformatf("reset slices d%0d", d), {o_s1[d], o_s2[d]}, 8'h00);
         for (int a = 0; a < 8; a++) begin
            i_dbg[d] = 3'(a);
            #1;
            chk($sformatf("reset dbg d%0d r%0d", d, a), o_dbg[d], 16'h0000);
         end
      end

      for (int i = 0; i < 9; i++)
         txn(tbl[i].d, tbl[i].a1, tbl[i].a2, tbl[i].ad, tbl[i].we, tbl[i].wd, tbl[i].junk,
             tbl[i].chain, tbl[i].e1, tbl[i].e2, tbl[i].erd, $sformatf("vec%0d", i));

      for (int d = 0; d < 2; d++) begin
         int b;
         b = (d == 0) ? 16 : 4;
         for (int i = 0; i < 25; i++) begin
            int a1, a2, ad, junk;
            bit we, chain;
            logic [15:0] wd, e1, e2, erd;
            a1 = $urandom_range(0, 7);
            a2 = $urandom_range(0, 7);
            ad = $urandom_range(0, 7);
            we = 1'($urandom_range(0, 1));
            wd = 16'($urandom);
            chain = (i < 24) && ($urandom_range(0, 1) == 1);
            junk = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, b - 2)) : -1;
            e1 = mread(d, a1);
            e2 = mread(d, a2);
            erd = mwr_ok(d, ad, we) ? wd : mread(d, ad);
            txn(d, a1, a2, ad, we, wd, junk, chain, e1, e2, erd, $sformatf("rnd d%0d #%0d", d, i));
         end
      end

      for (int d = 0; d < 2; d++)
         for (int a = 0; a < 8; a++) begin
            i_dbg[d] = 3'(a);
            #1;
            chk($sformatf("sweep d%0d r%0d", d, a), o_dbg[d], mread(d, a));
         end

      // Abort a write of 0xFFFF to r6 with reset asserted in beat 7.
      i_start[0] = 1'b1; i_rs1[0] = 3'd0; i_rs2[0] = 3'd0; i_rd[0] = 3'd6; i_we[0] = 1'b1;
      i_dbg[0] = 3'd6;
      step();
      i_start[0] = 1'b0;
      for (int k = 0; k < 8; k++) begin
         i_rds[0] = 4'h1;
         if (k == 7) begin
            rst = 1'b1;
            @(negedge clk);
            chk("abort partial r6", o_dbg[0], 16'h007F);
         end
         step();
      end
      @(negedge clk);
      chk("abort ctl", {o_busy[0], o_ready[0], o_last[0]}, 3'b010);
      chk("abort r6", o_dbg[0], 16'h0000);
      rst = 1'b0;
      clear_model();
      step();
      for (int d = 0; d < 2; d++)
         for (int a = 0; a < 8; a++) begin
            i_dbg[d] = 3'(a);
            #1;
            chk($sformatf("post-abort d%0d r%0d", d, a), o_dbg[d], mread(d, a));
         end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/serial_reg_file.md
# serial_reg_file

Bit-serial, parametrised register file for the serial datapath. A single `start` launches a transaction over `BEATS = XLEN/SLICE` beats. Each beat streams one `SLICE`-wide slice of two source registers LSB-first to the serial ALU and writes back one result slice into the destination register. It sits between decode and the serial ALU and generalises the current parallel 8×16 file in width, depth, slice width and zero-register mode. A parallel debug read port gives visibility for bring-up and verification.

## Interface
Parameters:
- `XLEN`, 16: register width in bits.
- `NREG`, 8: number of registers, at least 2.
- `SLICE`, 1: bits per beat. Must divide `XLEN`; elaboration error otherwise.
- `ZERO_REG`, 1: when 1, register 0 reads as 0 and writes to it are discarded.

Ports (`AW = $clog2(NREG)`):
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `start` in 1: launch a transaction. Honoured only while `ready`=1.
- `rs1`, `rs2`, `rd` in AW each: register addresses, sampled on an accepted `start`.
- `rd_we` in 1: write enable, sampled on an accepted `start`.
- `ready` out 1: a `start` in this cycle is accepted.
- `busy` out 1: a transaction beat is in progress.
- `last` out 1: the current beat is the final beat.
- `rs1_slice`, `rs2_slice` out SLICE: current source slices.
- `rd_slice` in SLICE: result slice for the current beat.
- `dbg_addr` in AW: debug read address.
- `dbg_data` out XLEN: combinational full-width read of `dbg_addr`, honouring `ZERO_REG`.

## Operation
- States: IDLE and RUN. Beat counter `cnt` has width `$clog2(BEATS)` (minimum 1).
- `ready = (state==IDLE) | last`. `busy = (state==RUN)`. `last = busy & (cnt==BEATS-1)`.
- IDLE: on `start`, latch `rs1`, `rs2`, `rd` and `rd_we` into `*_q`, clear `cnt`, go to RUN.
- RUN, not `last`: increment `cnt`.
- RUN, `last` with `start`: accept the new transaction back-to-back; relatch, clear `cnt`, stay in RUN.
- RUN, `last` without `start`: go to IDLE.
- `start` while `ready`=0 is ignored. No state change, no error.
- Read data: `rsN_slice = reg[rsN_q][cnt*SLICE +: SLICE]`. The value is 0 when `busy`=0, and 0 when `ZERO_REG` and `rsN_q`==0.
- Write data: in each RUN beat with `rd_we_q`, `rd_slice` is written into `reg[rd_q][cnt*SLICE +: SLICE]` at the clock edge. The write is suppressed when `ZERO_REG` and `rd_q`==0.
- Read-before-write: slice k is read before slice k of the same register is written, so `rd_q==rsN_q` needs no forwarding. The source stream always carries the pre-transaction value.
- Unwritten slices of `rd` hold their value. Other registers are untouched.

## Timing
- Reset: `state`=IDLE, `cnt`=0, all registers 0, `*_q`=0. Resulting outputs: `ready`=1, `busy`=0, `last`=0, slices 0, `dbg_data`=0.
- `rst` mid-transaction aborts immediately. Slices already written are lost because all registers clear.
- Latency: `start` accepted in cycle T gives beat k in cycle T+1+k. `last` is high in cycle T+BEATS.
- The full result is visible on `dbg_data` from cycle T+BEATS+1.
- Back-to-back throughput is one beat per cycle with no bubble.
- Slice outputs are combinational from registered state only; no input-to-output path.
- `dbg_data` is combinational from `dbg_addr` and register state.

## Structure
- Package `serial_rf_pkg` holds the state enum (`RF_IDLE`, `RF_RUN`) and helper functions for `BEATS` and `AW`. The package has no fixed-width types, because all widths come from parameters.
- Sub-module `serial_beat_ctr` (parameter `BEATS`; ports `clk`, `rst`, `clr`, `en`, `cnt`, `last`) is factored out. The serial ALU sequencer reuses it.
- Storage is a flat `NREG`×`XLEN` array. Slice select is an indexed part-select on `cnt`.

## Test plan
- Reset with `XLEN`=16, `SLICE`=1: all `dbg_data` reads return 0; `ready`=1, `busy`=0.
- Write r3 = 0xA5C3 (`rd_slice` streams 1,1,0,0,0,0,1,1,1,0,1,0,0,1,0,1 LSB-first): `last` is high in beat 15; `dbg_data`[r3] = 0xA5C3 at T+17.
- With r3 = 0xA5C3 and r5 = 0x0F0F, start `rs1`=3, `rs2`=5, `rd`=3 with `rd_slice` = 0xFFFF: `rs1_slice` streams 0xA5C3 (the old value), `rs2_slice` streams 0x0F0F, and r3 ends at 0xFFFF.
- `ZERO_REG`=1, write 0x1234 to r0: `rs1`=0 streams zeros, `dbg_data`[r0] = 0; with `ZERO_REG`=0 the same write makes r0 = 0x1234.
- `SLICE`=4: r2 = 0xBEEF is written in 4 beats; reading r2 yields `rs1_slice` F,E,E,B; `start` asserted in beat 2 is ignored; `start` asserted during `last` begins the next transaction in the following cycle.
- `rst` in beat 7 of a write of 0xFFFF to r6: `busy`=0 next cycle and r6 = 0.
